// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage FSM states and default fetch constants
package fetch_pkg;
    typedef enum logic [1:0] {F_REQ, F_WAIT, F_HAVE, F_DROP} fstate_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF  = 4;
endpackage

// File: rtl/flopenr.sv
// flopenr: enabled register with asynchronous active-high reset to INIT
//   clk, rst : clock, async reset
//   en_i     : load d_i on the rising edge
//   d_i/q_o  : data in / registered data out
module flopenr #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q_o <= INIT;
        else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (ARM W > RISC-V E > sequential) and PC incrementer
//   pcf_i                     : current fetch PC
//   pcsrc_w_i / result_w_i    : ARM r15 write retiring in W and its target
//   pcsrc_e_i / pc_target_e_i : RISC-V taken branch/jump in E and its target
//   pc_plus4_o                : pcf_i + PC_STEP (wraps mod 2^32)
//   pc_next_o                 : selected next PC
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEF
) (
    input  logic [31:0] pcf_i,
    input  logic        pcsrc_w_i,
    input  logic [31:0] result_w_i,
    input  logic        pcsrc_e_i,
    input  logic [31:0] pc_target_e_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_next_o
);
    assign pc_plus4_o = pcf_i + 32'(PC_STEP);
    // W carries the older instruction, so its redirect wins
    assign pc_next_o = pcsrc_w_i ? result_w_i : pcsrc_e_i ? pc_target_e_i : pc_plus4_o;
endmodule

// File: rtl/stage_f.sv
// stage_f: fetch stage - PC register, next-PC select, single-outstanding imem handshake
//   clk, rst            : clock, async active-high reset
//   StallF              : hold PCF and buffered instruction
//   PCSrcE, PCTargetE   : RISC-V redirect from E
//   PCSrcW, ResultW     : ARM r15 write redirect from W (higher priority)
//   IReq, IAddr, IReady : imem request channel (issue = IReq & IReady)
//   IRValid, IRData     : imem response channel
//   PCF, PCPlus4F, RDD  : fetch PC, PC + step, instruction for PCF
//   IMissF              : instruction for PCF not yet available
module stage_f
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IReady,
    input  logic        IRValid,
    input  logic [31:0] IRData,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] RDD,
    output logic        IMissF
);
    fstate_t     state_q, state_d;
    logic [31:0] pc_next, ibuf_q;
    logic        redirect, have, wait_hit, imiss, advance;

    assign redirect = PCSrcW | PCSrcE;
    assign have     = state_q == F_HAVE;
    // response cycle in F_WAIT is bypassed straight to RDD
    assign wait_hit = (state_q == F_WAIT) & IRValid;
    assign imiss    = ~(have | wait_hit);
    assign advance  = ~StallF & ~imiss;

    pc_next_sel #(.PC_STEP(PC_STEP)) u_sel (
        .pcf_i         (PCF),
        .pcsrc_w_i     (PCSrcW),
        .result_w_i    (ResultW),
        .pcsrc_e_i     (PCSrcE),
        .pc_target_e_i (PCTargetE),
        .pc_plus4_o    (PCPlus4F),
        .pc_next_o     (pc_next)
    );

    // redirects update PCF regardless of stall or miss
    flopenr #(.WIDTH(32), .INIT(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .en_i (advance | redirect),
        .d_i  (pc_next),
        .q_o  (PCF)
    );

    // capturing on a discarded response is harmless: the FSM leaves F_HAVE unused
    flopenr #(.WIDTH(32), .INIT(32'h0)) u_ibuf (
        .clk  (clk),
        .rst  (rst),
        .en_i (wait_hit),
        .d_i  (IRData),
        .q_o  (ibuf_q)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= F_REQ;
        else state_q <= state_d;

    // a request already issued for the old PC must be drained in F_DROP
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_REQ:   state_d = IReady ? (redirect ? F_DROP : F_WAIT) : F_REQ;
            F_WAIT:  state_d = IRValid ? ((redirect | advance) ? F_REQ : F_HAVE)
                                       : (redirect ? F_DROP : F_WAIT);
            F_HAVE:  state_d = (redirect | advance) ? F_REQ : F_HAVE;
            F_DROP:  state_d = IRValid ? F_REQ : F_DROP;
            default: state_d = F_REQ;
        endcase
    end

    always_comb begin
        IReq   = state_q == F_REQ;
        IAddr  = PCF;
        IMissF = imiss;
        RDD    = have ? ibuf_q : IRData;
    end

    // a response is only legal while a request is outstanding
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(IRValid && (state_q == F_REQ || have)));
endmodule
